// File: rtl/burst_stats.sv
// Burst statistics collector: tracks min/max/count (and optionally sum) of each run of
// valid samples and reports them with a one-cycle pulse. Define BURST_STATS_SUM_EN for sum_o.
module burst_stats #(
    parameter int WORD_LEN = 8,
    parameter int CNT_W    = 8,
    parameter int SUM_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_LEN-1:0] dat_i,
    input  logic                val_i,
    output logic [WORD_LEN-1:0] min_o,
    output logic [WORD_LEN-1:0] max_o,
    output logic [CNT_W-1:0]    cnt_o,
`ifdef BURST_STATS_SUM_EN
    output logic [SUM_W-1:0]    sum_o,
`endif
    output logic                val_o
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // The sum path zero-extends samples, so it must be at least as wide as a sample.
    if (SUM_W < WORD_LEN) begin : g_bad_sum_w
        $error("burst_stats: SUM_W must be >= WORD_LEN");
    end

    state_t              r_state, w_state_next;
    logic [WORD_LEN-1:0] r_min_acc, w_min_acc_next;
    logic [WORD_LEN-1:0] r_max_acc, w_max_acc_next;
    logic [CNT_W-1:0]    r_cnt_acc, w_cnt_acc_next;
    logic [WORD_LEN-1:0] r_min, w_min_next;
    logic [WORD_LEN-1:0] r_max, w_max_next;
    logic [CNT_W-1:0]    r_cnt, w_cnt_next;
    logic                r_val, w_val_next;
    logic [CNT_W-1:0]    w_cnt_inc;

    assign w_cnt_inc = (r_cnt_acc == {CNT_W{1'b1}}) ? r_cnt_acc : r_cnt_acc + CNT_W'(1);

`ifdef BURST_STATS_SUM_EN
    logic [SUM_W-1:0] r_sum_acc, w_sum_acc_next;
    logic [SUM_W-1:0] r_sum, w_sum_next;
    logic [SUM_W:0]   w_sum_wide;
    logic [SUM_W-1:0] w_sum_inc;

    // One extra bit catches the carry so the sum clamps instead of wrapping.
    assign w_sum_wide = {1'b0, r_sum_acc} + (SUM_W + 1)'(dat_i);
    assign w_sum_inc  = w_sum_wide[SUM_W] ? {SUM_W{1'b1}} : w_sum_wide[SUM_W-1:0];
`endif

    always_comb begin
        w_state_next   = r_state;
        w_min_acc_next = r_min_acc;
        w_max_acc_next = r_max_acc;
        w_cnt_acc_next = r_cnt_acc;
        w_min_next     = r_min;
        w_max_next     = r_max;
        w_cnt_next     = r_cnt;
        w_val_next     = 1'b0;
`ifdef BURST_STATS_SUM_EN
        w_sum_acc_next = r_sum_acc;
        w_sum_next     = r_sum;
`endif
        case (r_state)
            IDLE: begin
                if (val_i) begin
                    w_state_next   = ACC;
                    w_min_acc_next = dat_i;
                    w_max_acc_next = dat_i;
                    w_cnt_acc_next = CNT_W'(1);
`ifdef BURST_STATS_SUM_EN
                    w_sum_acc_next = SUM_W'(dat_i);
`endif
                end
            end
            ACC: begin
                if (val_i) begin
                    if (dat_i < r_min_acc) w_min_acc_next = dat_i;
                    if (dat_i > r_max_acc) w_max_acc_next = dat_i;
                    w_cnt_acc_next = w_cnt_inc;
`ifdef BURST_STATS_SUM_EN
                    w_sum_acc_next = w_sum_inc;
`endif
                end else begin
                    w_state_next = IDLE;
                    w_min_next   = r_min_acc;
                    w_max_next   = r_max_acc;
                    w_cnt_next   = r_cnt_acc;
                    w_val_next   = 1'b1;
`ifdef BURST_STATS_SUM_EN
                    w_sum_next   = r_sum_acc;
`endif
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_min_acc <= '0;
            r_max_acc <= '0;
            r_cnt_acc <= '0;
            r_min     <= '0;
            r_max     <= '0;
            r_cnt     <= '0;
            r_val     <= 1'b0;
`ifdef BURST_STATS_SUM_EN
            r_sum_acc <= '0;
            r_sum     <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_min_acc <= w_min_acc_next;
            r_max_acc <= w_max_acc_next;
            r_cnt_acc <= w_cnt_acc_next;
            r_min     <= w_min_next;
            r_max     <= w_max_next;
            r_cnt     <= w_cnt_next;
            r_val     <= w_val_next;
`ifdef BURST_STATS_SUM_EN
            r_sum_acc <= w_sum_acc_next;
            r_sum     <= w_sum_next;
`endif
        end
    end

    assign min_o = r_min;
    assign max_o = r_max;
    assign cnt_o = r_cnt;
    assign val_o = r_val;
`ifdef BURST_STATS_SUM_EN
    assign sum_o = r_sum;
`endif

endmodule
